// File: rtl/mod_reconstruct.sv
// ---------------------------------------------------------------------------
// mod_reconstruct
//
// Rebuilds dividend = divisor * quotient + remainder so that a divide/modulo
// result can be round-tripped and compared against the original dividend.
// The product comes from a sequential LSB-first shift-add multiplier. The
// remainder is then added, and the divisor==0 and remainder-out-of-range
// conditions are flagged. Both conditions are legal inputs, not errors of
// this block.
//
// Optional feature (compile-time macro):
//   MOD_RECON_EARLY_EXIT_EN
//     When defined, the multiply phase stops as soon as the remaining
//     multiplier bits are all zero (at least one MUL cycle is always spent).
//     Results and flags are identical to the default build; only latency
//     changes.
//
// Parameters:
//   WIDTH        operand width (>= 2); outDividend is 2*WIDTH bits
//
// Ports:
//   clk          in   single clock, all state on the rising edge
//   rst          in   synchronous active-high reset
//   start        in   request, sampled only while idle
//   inDivisor    in   WIDTH    divisor (multiplicand)
//   inQuotient   in   WIDTH    quotient (multiplier)
//   inRemainder  in   WIDTH    remainder to add
//   busy         out  high from the cycle after an accepted start until done
//   done         out  one-cycle pulse; outDividend/divZero/remErr valid
//   outDividend  out  2*WIDTH  reconstructed dividend
//   divZero      out  captured divisor was zero
//   remErr       out  captured divisor nonzero and remainder >= divisor
//   stateDbg     out  2        current FSM state (IDLE=0 MUL=1 ADD=2 DONE=3)
//
// Handshake: start is only looked at while the block is idle (busy=0 and
// done=0). An accepted start captures all three operands on that clock edge,
// so the inputs may change freely afterwards. busy then stays high until the
// done cycle. done pulses for exactly one cycle, and a new start is accepted
// in the cycle after done. start raised while busy or during done is
// ignored. outDividend and the flags are cleared by an accepted start, are
// loaded for the done cycle, and hold until the next accepted start or reset.
// ---------------------------------------------------------------------------
module mod_reconstruct #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   inDivisor,
  input  logic [WIDTH-1:0]   inQuotient,
  input  logic [WIDTH-1:0]   inRemainder,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] outDividend,
  output logic               divZero,
  output logic               remErr,
  output logic [1:0]         stateDbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             stateNext;

  logic [2*WIDTH-1:0] acc;        // running partial product, then final sum
  logic [2*WIDTH-1:0] mcand;      // multiplicand, shifted left once per MUL cycle
  logic [WIDTH-1:0]   mplier;     // multiplier, shifted right once per MUL cycle
  logic [WIDTH-1:0]   divisorCap; // captured divisor, used for the flags
  logic [WIDTH-1:0]   remCap;     // captured remainder
  logic [CW-1:0]      bitCnt;     // multiplier bit index being consumed
  logic               mulLast;    // current MUL cycle is the final one

  // The fixed build always consumes all WIDTH multiplier bits. The early-exit
  // build also stops once the bits still to be consumed after this cycle
  // (mplier >> 1) are all zero, because further cycles could only add zero.
  // The bit-count bound remains as a backstop in both builds.
  always_comb begin
    mulLast = (bitCnt == CW'(WIDTH - 1));
`ifdef MOD_RECON_EARLY_EXIT_EN
    if (mplier[WIDTH-1:1] == '0) begin
      mulLast = 1'b1;
    end
`else
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic and status outputs
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = MUL;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (mulLast) begin
          stateNext = ADD;
        end
      end
      ADD: begin
        busy      = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign stateDbg = state;

  // Datapath. The result registers are loaded on the ADD->DONE edge, so they
  // are already valid in the done cycle and then simply hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      divisorCap  <= '0;
      remCap      <= '0;
      bitCnt      <= '0;
      outDividend <= '0;
      divZero     <= 1'b0;
      remErr      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc         <= '0;
            mcand       <= {{WIDTH{1'b0}}, inDivisor};
            mplier      <= inQuotient;
            divisorCap  <= inDivisor;
            remCap      <= inRemainder;
            bitCnt      <= '0;
            outDividend <= '0;
            divZero     <= 1'b0;
            remErr      <= 1'b0;
          end
        end
        MUL: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          bitCnt <= bitCnt + CW'(1);
        end
        ADD: begin
          // The maximum is (2^W-1)^2 + (2^W-1) = 2^2W - 2^W, so the sum always
          // fits in 2*WIDTH bits. A zero divisor leaves acc at 0, which makes
          // the result equal to the remainder.
          acc         <= acc + {{WIDTH{1'b0}}, remCap};
          outDividend <= acc + {{WIDTH{1'b0}}, remCap};
          divZero     <= (divisorCap == '0);
          remErr      <= (divisorCap != '0) && (remCap >= divisorCap);
        end
        default: begin
          // DONE: results hold
        end
      endcase
    end
  end

endmodule
